// File: rtl/muldiv_seq_pkg.sv
// Shared RV32M funct3 encodings, sequencer state type and operand-signedness
// decode used by the iterative multiply/divide unit.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    FNC_MUL    = 3'b000,
    FNC_MULH   = 3'b001,
    FNC_MULHSU = 3'b010,
    FNC_MULHU  = 3'b011,
    FNC_DIV    = 3'b100,
    FNC_DIVU   = 3'b101,
    FNC_REM    = 3'b110,
    FNC_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // MUL yields the same low word either way, so it is treated as unsigned.
  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == FNC_MULH) || (f == FNC_MULHSU) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == FNC_MULH) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply (mode=0) or restoring
// divide (mode=1), both built around a single XLEN+1-bit adder.
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_nx,
  output logic [XLEN-1:0] lo_nx
);

  logic [XLEN:0]   add_a;
  logic [XLEN:0]   add_b;
  logic            cin;
  logic [XLEN+1:0] sum;
  logic            carry;

  always_comb begin
    add_a = '0;
    add_b = '0;
    cin   = 1'b0;
    if (mode) begin
      // Subtract via inverted divisor plus carry-in; carry-out means no borrow.
      add_a = {hi, lo[XLEN-1]};
      add_b = ~{1'b0, operand};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, hi};
      add_b = lo[0] ? {1'b0, operand} : '0;
    end
    sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, cin};
    carry = sum[XLEN+1];
  end

  always_comb begin
    hi_nx = '0;
    lo_nx = '0;
    if (mode) begin
      hi_nx = carry ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], carry};
    end else begin
      hi_nx = sum[XLEN:1];
      lo_nx = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: valid/ready in, XLEN iterations
// on a shared adder, sign correction, registered result with valid/ready out.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  state_e            state, state_nx;
  logic [2:0]        op;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   hi, lo, dvs;
  logic [CNT_W-1:0]  cnt;

  logic              in_sign_a, in_sign_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              last_step;

  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0]   quot_c, rem_c;
  logic [XLEN-1:0]   final_res;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign last_step = (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    in_sign_a   = a_is_signed(funct3) & A[XLEN-1];
    in_sign_b   = b_is_signed(funct3) & B[XLEN-1];
    abs_a       = in_sign_a ? (~A + 1'b1) : A;
    abs_b       = in_sign_b ? (~B + 1'b1) : B;
    div_zero    = funct3[2] && (B == '0);
    div_ovf     = funct3[2] && !funct3[0] &&
                  (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? A : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : A;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode    (op[2]),
    .hi      (hi),
    .lo      (lo),
    .operand (dvs),
    .hi_nx   (hi_nx),
    .lo_nx   (lo_nx)
  );

  // Sign correction works on the last iteration's output so DONE holds the final value.
  always_comb begin
    prod      = {hi_nx, lo_nx};
    prod_c    = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    quot_c    = (sign_a ^ sign_b) ? (~lo_nx + 1'b1) : lo_nx;
    rem_c     = sign_a ? (~hi_nx + 1'b1) : hi_nx;
    final_res = '0;
    if (op[2])
      final_res = op[1] ? rem_c : quot_c;
    else if (op == FNC_MUL)
      final_res = prod_c[XLEN-1:0];
    else
      final_res = prod_c[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) state_nx = special ? S_DONE : S_CALC;
      S_CALC: if (last_step) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (kill)
      state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (!kill) begin
        case (state)
          S_IDLE: begin
            if (in_valid) begin
              op     <= funct3;
              sign_a <= in_sign_a;
              sign_b <= in_sign_b;
              hi     <= '0;
              lo     <= abs_a;
              dvs    <= abs_b;
              cnt    <= '0;
              if (special)
                result <= special_res;
            end
          end
          S_CALC: begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + CNT_W'(1);
            if (last_step)
              result <= final_res;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: table-driven RV32M vectors with a result
// scoreboard, plus hand-written backpressure, kill and reset sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] A, B;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .A         (A),
    .B         (B),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        tbl[18];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    funct3   = f;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (as 1) until out_valid is seen.
  task automatic wait_valid(output int n, output logic ready_seen);
    n = 1;
    ready_seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_result"}, result, e);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_ovalid_after"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_iready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    logic        rdy;
    logic        stable;
    logic        seen;
    logic [31:0] hold;

    tbl[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    tbl[1]  = '{3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 33};
    tbl[2]  = '{3'b011, 32'h80000000,   32'h80000000, 32'h40000000, 33};
    tbl[3]  = '{3'b010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33};
    tbl[4]  = '{3'b101, 32'd100,        32'd7,        32'd14,       33};
    tbl[5]  = '{3'b111, 32'd100,        32'd7,        32'd2,        33};
    tbl[6]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
    tbl[7]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
    tbl[8]  = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
    tbl[9]  = '{3'b110, 32'd5,          32'd0,        32'd5,        1};
    tbl[10] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    tbl[11] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
    tbl[12] = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[13] = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        33};
    tbl[14] = '{3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    tbl[15] = '{3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,        33};
    tbl[16] = '{3'b101, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 33};
    tbl[17] = '{3'b111, 32'd5,          32'd0,        32'd5,        1};

    reset = 1'b1; in_valid = 1'b0; funct3 = '0; A = '0; B = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      accept(tbl[i].f, tbl[i].a, tbl[i].b);
      exp_q.push_back(tbl[i].exp);
      wait_valid(lat, rdy);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_busy_ready", i), {31'd0, rdy}, 32'd0);
      drain($sformatf("v%0d", i));
    end

    // Backpressure: result and out_valid must hold while out_ready is low.
    accept(3'b101, 32'd1000, 32'd9);
    exp_q.push_back(32'd111);
    wait_valid(lat, rdy);
    chk("bp_latency", lat, 33);
    hold   = exp_q[0];
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!out_valid || result !== hold || in_ready) stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    drain("bp");

    // Kill at counter 10 with a new request pending: nothing may be accepted.
    accept(3'b000, 32'd7, 32'hFFFFFFFD);
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; funct3 = 3'b100; A = 32'd5; B = 32'd0;
    @(posedge clk);
    #1;
    chk("kill_out_valid", {31'd0, out_valid}, 32'd0);
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    kill = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("kill_no_result", {31'd0, seen}, 32'd0);
    chk("kill_result_kept", result, 32'd111);

    // Reset at counter 20 discards the operation and clears result.
    accept(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    accept(3'b000, 32'd12345, 32'd1000);
    exp_q.push_back(32'd12345000);
    wait_valid(lat, rdy);
    chk("post_rst_latency", lat, 33);
    drain("post_rst");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
